// File: rtl/x7seg_share_ctrl.sv
// x7seg_share_ctrl: round-robin sharing of one x7seg driver among four requesters (optional blanking gap via X7SEG_CTRL_BLANK_EN)
module x7seg_share_ctrl #(
  parameter int         HOLD_CYCLES  = 25000000,
  parameter logic [7:0] IDLE_VAL     = 8'h00,
  parameter int         BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  req,
  input  logic [31:0] data,
  output logic [3:0]  ack,
  output logic        busy,
  output logic [7:0]  disp_x,
  output logic [1:0]  disp_src,
  output logic        disp_blank
);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
`ifdef X7SEG_CTRL_BLANK_EN
  localparam int GW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
`else
  typedef enum logic {IDLE, SHOW} state_t;
`endif
  state_t        r_state, w_state_n;
  logic [1:0]    r_ptr, w_ptr_n, w_ptr_arb;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [7:0]    r_x, w_x_n;
  logic [1:0]    r_src, w_src_n;
  logic          r_busy, w_busy_n;
  logic [3:0]    r_ack, w_ack_n;
  logic          w_arb;
  logic [3:0]    w_mask;
  logic [2:0]    w_pick;
`ifdef X7SEG_CTRL_BLANK_EN
  logic [GW-1:0] r_gcnt, w_gcnt_n;
  logic          r_blank, w_blank_n;
`endif
  // first set request bit scanning upward from p (wrapping); {found, index}
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] w;
    logic [1:0] idx;
    w = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) w = {1'b1, idx};
    end
    return w;
  endfunction
  // next-state: window countdown, window-end ack, and arbitration when a new window may start
  always_comb begin
    w_state_n = r_state;
    w_ptr_n   = r_ptr;
    w_cnt_n   = r_cnt;
    w_x_n     = r_x;
    w_src_n   = r_src;
    w_busy_n  = r_busy;
    w_ack_n   = '0;
    w_arb     = 1'b0;
    w_ptr_arb = r_ptr;
    w_mask    = '0;
`ifdef X7SEG_CTRL_BLANK_EN
    w_gcnt_n  = r_gcnt;
    w_blank_n = 1'b0;
`endif
    case (r_state)
      IDLE: w_arb = 1'b1;
      SHOW:
        if (r_cnt == '0) begin
          w_ack_n = 4'b0001 << r_src;
          w_ptr_n = r_src + 2'd1;
`ifdef X7SEG_CTRL_BLANK_EN
          w_state_n = GAP;
          w_x_n     = IDLE_VAL;
          w_busy_n  = 1'b0;
          w_blank_n = 1'b1;
          w_gcnt_n  = GW'(BLANK_CYCLES - 1);
`else
          w_arb     = 1'b1;
          w_ptr_arb = r_src + 2'd1;
          w_mask    = 4'b0001 << r_src;
`endif
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
`ifdef X7SEG_CTRL_BLANK_EN
      GAP:
        if (r_gcnt == '0) begin
          w_arb = 1'b1;
        end else begin
          w_gcnt_n  = r_gcnt - 1'b1;
          w_blank_n = 1'b1;
        end
`endif
      default: ;
    endcase
    w_pick = pick(req & ~w_mask, w_ptr_arb);
    if (w_arb) begin
      if (w_pick[2]) begin
        w_state_n = SHOW;
        w_x_n     = data[8*w_pick[1:0] +: 8];
        w_src_n   = w_pick[1:0];
        w_busy_n  = 1'b1;
        w_cnt_n   = CW'(HOLD_CYCLES - 1);
      end else begin
        w_state_n = IDLE;
        w_x_n     = IDLE_VAL;
        w_busy_n  = 1'b0;
      end
    end
  end
  // state and output registers; clr clears immediately and drops any pending ack
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_x     <= IDLE_VAL;
      r_src   <= '0;
      r_busy  <= 1'b0;
      r_ack   <= '0;
`ifdef X7SEG_CTRL_BLANK_EN
      r_gcnt  <= '0;
      r_blank <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_ptr   <= w_ptr_n;
      r_cnt   <= w_cnt_n;
      r_x     <= w_x_n;
      r_src   <= w_src_n;
      r_busy  <= w_busy_n;
      r_ack   <= w_ack_n;
`ifdef X7SEG_CTRL_BLANK_EN
      r_gcnt  <= w_gcnt_n;
      r_blank <= w_blank_n;
`endif
    end
  end
  assign ack      = r_ack;
  assign busy     = r_busy;
  assign disp_x   = r_x;
  assign disp_src = r_src;
`ifdef X7SEG_CTRL_BLANK_EN
  assign disp_blank = r_blank;
`else
  assign disp_blank = (BLANK_CYCLES < 0);
`endif
endmodule

// File: tb/tb_x7seg_share_ctrl.sv
// tb_x7seg_share_ctrl: directed scoreboard bench for x7seg_share_ctrl with HOLD_CYCLES=4 (default build)
module tb_x7seg_share_ctrl;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic [3:0]  ack;
  logic        busy;
  logic [7:0]  disp_x;
  logic [1:0]  disp_src;
  logic        disp_blank;
  typedef struct {
    string      tag;
    logic [7:0] x;
    logic       b;
    logic [3:0] a;
    logic [1:0] s;
  } exp_t;
  exp_t sb[$];
  int total = 0;
  int passed = 0;
  int fails = 0;
  logic [3:0] rearm;
  x7seg_share_ctrl #(.HOLD_CYCLES(4), .IDLE_VAL(8'h00), .BLANK_CYCLES(2)) dut (
    .clk(clk), .clr(clr), .req(req), .data(data), .ack(ack), .busy(busy),
    .disp_x(disp_x), .disp_src(disp_src), .disp_blank(disp_blank)
  );
  always #5 clk = ~clk;
  task automatic push(input string t, input logic [7:0] x, input logic b, input logic [3:0] a, input logic [1:0] s);
    exp_t e;
    e.tag = t; e.x = x; e.b = b; e.a = a; e.s = s;
    sb.push_back(e);
  endtask
  task automatic cmp();
    exp_t e;
    if (sb.size() == 0) begin
      total++; fails++;
      $error("FAIL scoreboard_empty got none expected entry");
      return;
    end
    e = sb.pop_front();
    total += 5;
    assert (disp_x === e.x) passed++; else begin fails++; $error("FAIL %s disp_x got %h expected %h", e.tag, disp_x, e.x); end
    assert (busy === e.b) passed++; else begin fails++; $error("FAIL %s busy got %b expected %b", e.tag, busy, e.b); end
    assert (ack === e.a) passed++; else begin fails++; $error("FAIL %s ack got %b expected %b", e.tag, ack, e.a); end
    assert (disp_src === e.s) passed++; else begin fails++; $error("FAIL %s disp_src got %0d expected %0d", e.tag, disp_src, e.s); end
    assert (disp_blank === 1'b0) passed++; else begin fails++; $error("FAIL %s disp_blank got %b expected 0", e.tag, disp_blank); end
  endtask
  task automatic nxt(input string t, input logic [7:0] x, input logic b, input logic [3:0] a, input logic [1:0] s);
    push(t, x, b, a, s);
    @(posedge clk);
    #1;
    cmp();
  endtask
  task automatic now(input string t, input logic [7:0] x, input logic b, input logic [3:0] a, input logic [1:0] s);
    push(t, x, b, a, s);
    cmp();
  endtask
  initial begin
    #50;
    now("reset", 8'h00, 1'b0, 4'b0000, 2'd0);
    #50;
    clr = 1'b0;
    for (int i = 0; i < 20; i++) nxt("idle_after_reset", 8'h00, 1'b0, 4'b0000, 2'd0);
    req = 4'b0001;
    data = 32'h0000000A;
    for (int i = 0; i < 4; i++) nxt("single_window", 8'h0A, 1'b1, 4'b0000, 2'd0);
    nxt("single_ack", 8'h00, 1'b0, 4'b0001, 2'd0);
    req = 4'b0000;
    nxt("single_idle", 8'h00, 1'b0, 4'b0000, 2'd0);
    req = 4'b0001;
    data = 32'h0000005A;
    for (int i = 0; i < 4; i++) nxt("mask_window", 8'h5A, 1'b1, 4'b0000, 2'd0);
    nxt("mask_ack", 8'h00, 1'b0, 4'b0001, 2'd0);
    req = 4'b0000;
    for (int i = 0; i < 3; i++) nxt("mask_no_regrant", 8'h00, 1'b0, 4'b0000, 2'd0);
    #2 clr = 1'b1;
    #1 now("idle_reset", 8'h00, 1'b0, 4'b0000, 2'd0);
    #1 clr = 1'b0;
    @(posedge clk);
    #1;
    req = 4'b1111;
    data = 32'h13121110;
    rearm = '0;
    for (int w = 0; w < 5; w++) begin
      for (int c = 0; c < 4; c++) begin
        nxt("round_robin", 8'h10 + 8'(w % 4), 1'b1,
            (c == 0 && w > 0) ? (4'b0001 << ((w - 1) % 4)) : 4'b0000, 2'(w % 4));
        req = (req | rearm) & ~ack;
        rearm = ack;
        if (w == 4 && c == 1) begin
          req = 4'b0001;
          rearm = '0;
        end
      end
    end
    nxt("rr_last_ack", 8'h00, 1'b0, 4'b0001, 2'd0);
    req = 4'b0000;
    nxt("rr_idle", 8'h00, 1'b0, 4'b0000, 2'd0);
    req = 4'b0100;
    data = 32'h003C0000;
    nxt("latch_grant", 8'h3C, 1'b1, 4'b0000, 2'd2);
    nxt("latch_cycle1", 8'h3C, 1'b1, 4'b0000, 2'd2);
    data = 32'h00550000;
    nxt("latch_hold", 8'h3C, 1'b1, 4'b0000, 2'd2);
    nxt("latch_hold", 8'h3C, 1'b1, 4'b0000, 2'd2);
    nxt("latch_ack", 8'h00, 1'b0, 4'b0100, 2'd2);
    req = 4'b0000;
    nxt("latch_idle_src_held", 8'h00, 1'b0, 4'b0000, 2'd2);
    req = 4'b0010;
    data = 32'h00007700;
    for (int i = 0; i < 3; i++) nxt("pre_reset_window", 8'h77, 1'b1, 4'b0000, 2'd1);
    #2 clr = 1'b1;
    #1 now("mid_window_reset", 8'h00, 1'b0, 4'b0000, 2'd0);
    #2 clr = 1'b0;
    for (int i = 0; i < 4; i++) nxt("regrant_after_reset", 8'h77, 1'b1, 4'b0000, 2'd1);
    nxt("regrant_ack", 8'h00, 1'b0, 4'b0010, 2'd1);
    req = 4'b0000;
    nxt("final_idle", 8'h00, 1'b0, 4'b0000, 2'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
